// File: rtl/vga_timing_pkg.sv
// Shared timing constants and the decoded-signal bundle used by the VGA timing engine.
// The defaults describe the 800x600 @ 60 Hz (40 MHz pixel clock) mode.
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE      = 800;
   localparam int DEF_H_FRONT_PORCH = 40;
   localparam int DEF_H_SYNCH       = 128;
   localparam int DEF_H_BACK_PORCH  = 88;
   localparam int DEF_V_ACTIVE      = 600;
   localparam int DEF_V_FRONT_PORCH = 1;
   localparam int DEF_V_SYNCH       = 4;
   localparam int DEF_V_BACK_PORCH  = 23;
   localparam int DEF_PIPE_DELAY    = 2;
   localparam int MAX_PIPE_DELAY    = 7;
   localparam int DEF_PW            = 11;
   localparam int DEF_LW            = 10;

   // Decoded timing, always active-high; polarity is applied only at the outputs.
   typedef struct packed {
      logic h_s;
      logic v_s;
      logic csync;
      logic blank;
      logic line_start;
      logic frame_start;
   } timing_dec_t;

   localparam timing_dec_t DEC_IDLE = '{h_s: 1'b0, v_s: 1'b0, csync: 1'b0,
                                        blank: 1'b1, line_start: 1'b0,
                                        frame_start: 1'b0};

   function automatic int span_total(input int a, input int b, input int c, input int d);
      return a + b + c + d;
   endfunction

endpackage

// File: rtl/timing_delay_line.sv
// Enable-gated shift register with a per-bit reset pattern; DEPTH=0 degenerates to a wire.
module timing_delay_line #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             pixel_clock,
   input  logic             reset_n,
   input  logic             pixel_en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_ctrl;
         assign unused_ctrl = &{1'b0, pixel_clock, reset_n, pixel_en};
         assign dout        = din;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage [DEPTH];

         always_ff @(posedge pixel_clock or negedge reset_n) begin
            if (!reset_n) begin
               for (int i = 0; i < DEPTH; i++) begin
                  stage[i] <= RST_VAL;
               end
            end else if (pixel_en) begin
               stage[0] <= din;
               for (int i = 1; i < DEPTH; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_engine.sv
// VGA raster timing generator: pixel/line counters, range decode, DAC-matched delay
// pipeline and output polarity. Everything advances only on enabled pixel clocks.
module vga_timing_engine
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE      = DEF_H_ACTIVE,
   parameter int H_FRONT_PORCH = DEF_H_FRONT_PORCH,
   parameter int H_SYNCH       = DEF_H_SYNCH,
   parameter int H_BACK_PORCH  = DEF_H_BACK_PORCH,
   parameter int V_ACTIVE      = DEF_V_ACTIVE,
   parameter int V_FRONT_PORCH = DEF_V_FRONT_PORCH,
   parameter int V_SYNCH       = DEF_V_SYNCH,
   parameter int V_BACK_PORCH  = DEF_V_BACK_PORCH,
   parameter bit H_POL         = 1'b1,
   parameter bit V_POL         = 1'b1,
   parameter int PIPE_DELAY    = DEF_PIPE_DELAY,
   parameter int PW            = DEF_PW,
   parameter int LW            = DEF_LW
) (
   input  logic          pixel_clock,
   input  logic          reset_n,
   input  logic          pixel_en,
   output logic          h_synch,
   output logic          v_synch,
   output logic          comp_synch,
   output logic          blank,
   output logic          de,
   output logic          line_start,
   output logic          frame_start,
   output logic [PW-1:0] pixel_count,
   output logic [LW-1:0] line_count
);

   localparam int H_TOTAL = span_total(H_ACTIVE, H_FRONT_PORCH, H_SYNCH, H_BACK_PORCH);
   localparam int V_TOTAL = span_total(V_ACTIVE, V_FRONT_PORCH, V_SYNCH, V_BACK_PORCH);

   // Out-of-range delays are clamped to what the DAC pipeline can need.
   localparam int DELAY = (PIPE_DELAY > MAX_PIPE_DELAY) ? MAX_PIPE_DELAY :
                          (PIPE_DELAY < 0)              ? 0 : PIPE_DELAY;

   localparam logic [PW-1:0] H_LAST    = PW'(H_TOTAL - 1);
   localparam logic [PW-1:0] H_ACT_END = PW'(H_ACTIVE);
   localparam logic [PW-1:0] H_S_START = PW'(H_ACTIVE + H_FRONT_PORCH);
   localparam logic [PW-1:0] H_S_END   = PW'(H_ACTIVE + H_FRONT_PORCH + H_SYNCH);
   localparam logic [LW-1:0] V_LAST    = LW'(V_TOTAL - 1);
   localparam logic [LW-1:0] V_ACT_END = LW'(V_ACTIVE);
   localparam logic [LW-1:0] V_S_START = LW'(V_ACTIVE + V_FRONT_PORCH);
   localparam logic [LW-1:0] V_S_END   = LW'(V_ACTIVE + V_FRONT_PORCH + V_SYNCH);

   logic        end_of_line;
   logic        h_act;
   logic        v_act;
   logic        h_s;
   logic        v_s;
   timing_dec_t dec_p0;
   timing_dec_t dec_p1;
   timing_dec_t dec_p2;

   assign end_of_line = (pixel_count == H_LAST);

   always_ff @(posedge pixel_clock or negedge reset_n) begin
      if (!reset_n) begin
         pixel_count <= '0;
         line_count  <= '0;
      end else if (pixel_en) begin
         if (end_of_line) begin
            pixel_count <= '0;
            line_count  <= (line_count == V_LAST) ? '0 : line_count + 1'b1;
         end else begin
            pixel_count <= pixel_count + 1'b1;
         end
      end
   end

   // Stage p0: combinational range decode of the live counters.
   assign h_act = (pixel_count < H_ACT_END);
   assign h_s   = (pixel_count >= H_S_START) && (pixel_count < H_S_END);
   assign v_act = (line_count < V_ACT_END);
   assign v_s   = (line_count >= V_S_START) && (line_count < V_S_END);

   always_comb begin
      dec_p0             = DEC_IDLE;
      dec_p0.h_s         = h_s;
      dec_p0.v_s         = v_s;
      dec_p0.csync       = h_s ^ v_s;
      dec_p0.blank       = ~(h_act & v_act);
      dec_p0.line_start  = (pixel_count == '0);
      dec_p0.frame_start = (pixel_count == '0) && (line_count == '0);
   end

   // Stage p1: single decode register.
   always_ff @(posedge pixel_clock or negedge reset_n) begin
      if (!reset_n) begin
         dec_p1 <= DEC_IDLE;
      end else if (pixel_en) begin
         dec_p1 <= dec_p0;
      end
   end

   // Stage p2: DAC-matching delay.
   timing_delay_line #(
      .WIDTH   ($bits(timing_dec_t)),
      .DEPTH   (DELAY),
      .RST_VAL (DEC_IDLE)
   ) u_delay (
      .pixel_clock (pixel_clock),
      .reset_n     (reset_n),
      .pixel_en    (pixel_en),
      .din         (dec_p1),
      .dout        (dec_p2)
   );

   assign h_synch     = dec_p2.h_s ^ ~H_POL;
   assign v_synch     = dec_p2.v_s ^ ~V_POL;
   assign comp_synch  = dec_p2.csync ^ ~H_POL;
   assign blank       = dec_p2.blank;
   assign de          = ~dec_p2.blank;
   assign line_start  = dec_p2.line_start;
   assign frame_start = dec_p2.frame_start;

endmodule

// File: tb/tb_vga_timing_engine.sv
// Scoreboard bench: three engines (small, small inverted-polarity, default 800x600) driven
// with shared random enable/reset, compared each edge against an index-based raster model.
module tb_vga_timing_engine;

   localparam int SH_A = 8, SH_F = 2, SH_S = 3, SH_B = 2;
   localparam int SV_A = 4, SV_F = 1, SV_S = 2, SV_B = 1;
   localparam int SPD  = 2;
   localparam int S_HT = 15, S_VT = 8;

   logic pixel_clock = 1'b0;
   logic reset_n;
   logic pixel_en;

   always #5 pixel_clock = ~pixel_clock;

   logic       m_h, m_v, m_c, m_blank, m_de, m_ls, m_fs;
   logic [3:0] m_pc;
   logic [2:0] m_lc;
   logic       p_h, p_v, p_c, p_blank, p_de, p_ls, p_fs;
   logic [3:0] p_pc;
   logic [2:0] p_lc;
   logic        d_h, d_v, d_c, d_blank, d_de, d_ls, d_fs;
   logic [10:0] d_pc;
   logic [9:0]  d_lc;

   vga_timing_engine #(
      .H_ACTIVE(SH_A), .H_FRONT_PORCH(SH_F), .H_SYNCH(SH_S), .H_BACK_PORCH(SH_B),
      .V_ACTIVE(SV_A), .V_FRONT_PORCH(SV_F), .V_SYNCH(SV_S), .V_BACK_PORCH(SV_B),
      .H_POL(1'b1), .V_POL(1'b1), .PIPE_DELAY(SPD), .PW(4), .LW(3)
   ) u_main (
      .pixel_clock(pixel_clock), .reset_n(reset_n), .pixel_en(pixel_en),
      .h_synch(m_h), .v_synch(m_v), .comp_synch(m_c), .blank(m_blank), .de(m_de),
      .line_start(m_ls), .frame_start(m_fs), .pixel_count(m_pc), .line_count(m_lc)
   );

   vga_timing_engine #(
      .H_ACTIVE(SH_A), .H_FRONT_PORCH(SH_F), .H_SYNCH(SH_S), .H_BACK_PORCH(SH_B),
      .V_ACTIVE(SV_A), .V_FRONT_PORCH(SV_F), .V_SYNCH(SV_S), .V_BACK_PORCH(SV_B),
      .H_POL(1'b0), .V_POL(1'b0), .PIPE_DELAY(SPD), .PW(4), .LW(3)
   ) u_pol (
      .pixel_clock(pixel_clock), .reset_n(reset_n), .pixel_en(pixel_en),
      .h_synch(p_h), .v_synch(p_v), .comp_synch(p_c), .blank(p_blank), .de(p_de),
      .line_start(p_ls), .frame_start(p_fs), .pixel_count(p_pc), .line_count(p_lc)
   );

   vga_timing_engine u_def (
      .pixel_clock(pixel_clock), .reset_n(reset_n), .pixel_en(pixel_en),
      .h_synch(d_h), .v_synch(d_v), .comp_synch(d_c), .blank(d_blank), .de(d_de),
      .line_start(d_ls), .frame_start(d_fs), .pixel_count(d_pc), .line_count(d_lc)
   );

   typedef struct packed {
      logic [38:0] m;
      logic [38:0] p;
      logic [38:0] d;
   } exp_t;

   exp_t exp_q[$];
   exp_t async_q[$];
   int   e = 0;
   int   n_pass = 0;
   int   n_total = 0;

   // Expected observation after e enabled edges since reset: counters show raster index e,
   // decoded outputs show raster index e-1-pd (reset levels while that index is negative).
   function automatic logic [38:0] model(input int k, input int ha, input int hf, input int hs,
                                         input int hb, input int va, input int vf, input int vs,
                                         input int vb, input int pd, input bit hp, input bit vp);
      int   ht, vt, idx, p, l;
      logic hsy, vsy, act, h, v, c, bl, ls, fs;
      ht = ha + hf + hs + hb;
      vt = va + vf + vs + vb;
      h  = ~hp;
      v  = ~vp;
      c  = ~hp;
      bl = 1'b1;
      ls = 1'b0;
      fs = 1'b0;
      if (k >= 1 + pd) begin
         idx = k - 1 - pd;
         p   = idx % ht;
         l   = (idx / ht) % vt;
         hsy = (p >= ha + hf) && (p < ha + hf + hs);
         vsy = (l >= va + vf) && (l < va + vf + vs);
         act = (p < ha) && (l < va);
         h   = hp ? hsy : ~hsy;
         v   = vp ? vsy : ~vsy;
         c   = hp ? (hsy ^ vsy) : ~(hsy ^ vsy);
         bl  = ~act;
         ls  = (p == 0);
         fs  = (p == 0) && (l == 0);
      end
      return {16'(k % ht), 16'((k / ht) % vt), h, v, c, bl, ~bl, ls, fs};
   endfunction

   function automatic exp_t expect_at(input int k);
      exp_t x;
      x.m = model(k, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, SPD, 1'b1, 1'b1);
      x.p = model(k, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, SPD, 1'b0, 1'b0);
      x.d = model(k, 800, 40, 128, 88, 600, 1, 4, 23, 2, 1'b1, 1'b1);
      return x;
   endfunction

   task automatic check(input string name, input logic [38:0] got, input logic [38:0] want);
      n_total++;
      if (got === want) begin
         n_pass++;
      end else begin
         $display("FAIL %s at %0t: got pc=%0d lc=%0d hvc_blank_de_ls_fs=%b, expected pc=%0d lc=%0d hvc_blank_de_ls_fs=%b",
                  name, $time, got[38:23], got[22:7], got[6:0], want[38:23], want[22:7], want[6:0]);
      end
   endtask

   task automatic compare_all(input string tag, input exp_t x);
      check({tag, "_main"}, {16'(m_pc), 16'(m_lc), m_h, m_v, m_c, m_blank, m_de, m_ls, m_fs}, x.m);
      check({tag, "_pol"},  {16'(p_pc), 16'(p_lc), p_h, p_v, p_c, p_blank, p_de, p_ls, p_fs}, x.p);
      check({tag, "_def"},  {16'(d_pc), 16'(d_lc), d_h, d_v, d_c, d_blank, d_de, d_ls, d_fs}, x.d);
   endtask

   task automatic drive(input logic en, input logic rn);
      if (reset_n === 1'b1 && rn === 1'b0) begin
         async_q.push_back(expect_at(0));
      end
      pixel_en = en;
      reset_n  = rn;
      if (!rn) begin
         e = 0;
      end else if (en) begin
         e = e + 1;
      end
      exp_q.push_back(expect_at(e));
   endtask

   task automatic cyc(input logic en, input logic rn);
      @(negedge pixel_clock);
      drive(en, rn);
   endtask

   // Edge monitor: one expectation per rising edge.
   initial begin
      forever begin
         @(posedge pixel_clock);
         #1;
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL edge_queue at %0t: got empty scoreboard, expected an entry", $time);
         end else begin
            compare_all("edge", exp_q.pop_front());
         end
      end
   end

   // Reset monitor: outputs must collapse right after reset_n falls, before any clock edge.
   initial begin
      wait (reset_n === 1'b1);
      forever begin
         @(negedge reset_n);
         #1;
         if (async_q.size() == 0) begin
            n_total++;
            $display("FAIL async_queue at %0t: got empty scoreboard, expected an entry", $time);
         end else begin
            compare_all("async_rst", async_q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no completion by %0t, expected finish", $time);
      $fatal(1, "bench timeout");
   end

   initial begin
      bit hit;
      pixel_en = 1'b0;
      drive(1'b1, 1'b0);
      repeat (3) cyc(1'b1, 1'b0);
      repeat (300) cyc(1'b1, 1'b1);
      for (int i = 0; i < 260; i++) begin
         cyc((i % 2) == 0, 1'b1);
      end
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 1)), 1'b1);
      end
      hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
         cyc(1'b1, 1'b1);
         hit = ((e % S_HT) == 5) && (((e / S_HT) % S_VT) == 2);
      end
      n_total++;
      if (hit) begin
         n_pass++;
      end else begin
         $display("FAIL reset_point: got e=%0d, expected to reach pc=5 lc=2", e);
      end
      repeat (3) cyc(1'b1, 1'b0);
      repeat (2300) cyc(1'b1, 1'b1);
      @(posedge pixel_clock);
      #2;
      n_total++;
      if (exp_q.size() == 0 && async_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL drain: got %0d/%0d pending entries, expected 0/0", exp_q.size(), async_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/vga_timing_engine.md
VGA_TIMING_ENGINE -- requirements
Module: vga_timing_engine

Interface
REQ-001 The block SHALL have the following parameters, given as name, default, meaning:
- H_ACTIVE, 800, visible pixels per line
- H_FRONT_PORCH, 40, pixels from end of active video to start of h sync
- H_SYNCH, 128, h sync width in pixels
- H_BACK_PORCH, 88, pixels from end of h sync to end of line
- V_ACTIVE, 600, visible lines per frame
- V_FRONT_PORCH, 1, lines from end of active video to start of v sync
- V_SYNCH, 4, v sync width in lines
- V_BACK_PORCH, 23, lines from end of v sync to end of frame
- H_POL, 1, h_synch/comp_synch polarity (1 = active-high)
- V_POL, 1, v_synch polarity (1 = active-high)
- PIPE_DELAY, 2, extra output delay stages (0..7) matching the DAC pipeline
- PW, 11, pixel_count width
- LW, 10, line_count width
REQ-002 The block SHALL have the following ports, given as name, direction, width, meaning:
- pixel_clock, in, 1, sole clock
- reset_n, in, 1, asynchronous active-low reset
- pixel_en, in, 1, clock enable; all state advances only when high
- h_synch, out, 1, horizontal sync
- v_synch, out, 1, vertical sync
- comp_synch, out, 1, composite sync
- blank, out, 1, composite blanking (1 = blank)
- de, out, 1, data enable; always ~blank
- line_start, out, 1, one-cycle pulse aligned with the first pixel of every line
- frame_start, out, 1, one-cycle pulse aligned with pixel 0 of line 0
- pixel_count, out, PW, current pixel counter (undelayed)
- line_count, out, LW, current line counter (undelayed)

Function
REQ-003 H_TOTAL SHALL equal the sum of the four H_ parameters, and V_TOTAL SHALL equal the sum of the four V_ parameters.
REQ-004 When pixel_en=1, pixel_count SHALL increment by 1 per cycle and wrap from H_TOTAL-1 to 0.
REQ-005 When pixel_en=1 and pixel_count=H_TOTAL-1, line_count SHALL increment, or wrap from V_TOTAL-1 to 0.
REQ-006 When pixel_en=0, the counters, every decode register and every delay stage SHALL hold their values.
REQ-007 The block SHALL decode the current counts, with all signals active-high at this point:
- h_act = pc < H_ACTIVE
- h_s = H_ACTIVE+H_FRONT_PORCH <= pc < H_ACTIVE+H_FRONT_PORCH+H_SYNCH
- v_act and v_s use the same ranges applied to line_count
- blank_raw = ~(h_act & v_act)
- csync_raw = h_s ^ v_s
REQ-008 The decoded signals SHALL be registered once and then passed through PIPE_DELAY further stages, so the outputs for counter state at enabled cycle t appear after 1+PIPE_DELAY enabled cycles.
REQ-009 line_start and frame_start SHALL be decoded from pc==0 (and lc==0 for frame_start) and SHALL use the same 1+PIPE_DELAY latency as the other decoded outputs.
REQ-010 Output polarity SHALL be applied after the pipeline:
- h_synch = h_s XOR ~H_POL
- v_synch = v_s XOR ~V_POL
- comp_synch = csync_raw XOR ~H_POL
REQ-011 v_s and v_act SHALL change only at line boundaries, concurrent with the line_count update.
REQ-012 line_start and frame_start SHALL each be high for exactly one enabled cycle per occurrence.

Reset
REQ-013 While reset_n=0, all outputs and registers SHALL take their reset values:
- pixel_count=0 and line_count=0
- all delay stages cleared, with syncs at their inactive level (h_synch=~H_POL, v_synch=~V_POL, comp_synch=~H_POL)
- blank=1, de=0, line_start=0, frame_start=0
REQ-014 Reset assertion SHALL take effect immediately, regardless of pixel_clock.
REQ-015 After reset deassertion, the first enabled edge SHALL move pixel_count to 1, and outputs for pc=0/lc=0 SHALL appear at enabled edge 1+PIPE_DELAY.
REQ-016 A reset asserted mid-frame SHALL discard all in-flight pipeline contents.

Structure
REQ-017 The default timing constants (800x600 set) and a PIPE_DELAY maximum constant SHALL reside in the shared package vga_timing_pkg.
REQ-018 The delay pipeline SHALL be one sub-module, timing_delay_line, with the following properties:
- parameters WIDTH and DEPTH, where DEPTH=0 is a wire
- inputs pixel_clock, reset_n and pixel_en
- per-bit reset values supplied by parameter
REQ-019 The total implementation SHALL be purely synchronous to pixel_clock, with no combinational output paths.

Verification
REQ-020 Test with small params (H 8/2/3/2, H_TOTAL 15; V 4/1/2/1, V_TOTAL 8; PIPE_DELAY=2; pixel_en=1):
- h_synch SHALL be high for enabled edges where the registered pc was 10..12 (pc 10..12 plus 3 cycles)
- blank SHALL be low only for pc 0..7 of lines 0..3
REQ-021 Wrap test: at pc=14 and lc=7, the next edge SHALL give pc=0 and lc=0, and frame_start SHALL pulse exactly 3 cycles later, once per 120 cycles.
REQ-022 Enable gating: toggle pixel_en 1/0 alternately for a full frame; the output sequence sampled on enabled cycles SHALL be identical to the pixel_en=1 run, with frame_start every 240 clocks.
REQ-023 Polarity: with H_POL=0 and V_POL=0:
- h_synch SHALL be low during pc 10..12
- v_synch SHALL be low for lines 5..6
- during reset, h_synch and v_synch SHALL be 1
REQ-024 Mid-frame reset: assert reset_n=0 at pc=5, lc=2; outputs SHALL go to reset values asynchronously, and after release the sequence SHALL restart from pc=0 with no stale sync pulse.
REQ-025 Default 800x600 run: line period SHALL be 1056 enabled cycles, frame period 663168, v_synch high for 4 lines starting at line 601, de high for 800x600 cycles per frame.
